execute_md_stage: RTL and testbench
===================================

Name: execute_md_stage

Overview:
- Parametrised next-generation execute stage that adds the RV32M multiply/divide extension to the existing EX-stage datapath.
- Performs operand forwarding from the EX/MEM and MEM/WB stages.
- Runs a multi-cycle multiply/divide FSM that stalls upstream stages while busy.
- Owns the EX/MEM pipeline register. Non-M instructions pass through in one cycle using the result of the existing base ALU.

Parameters:
- XLEN, 32, datapath width.
- MUL_STAGES, 2, multiply latency in cycles (legal 1..4).
- DIV_BITS_PER_CYCLE, 1, quotient bits retired per cycle (1 or 2). XLEN must be divisible by it.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  ID/EX holds a valid instruction
- id_pc  in  XLEN  instruction PC
- id_instr  in  32  instruction word
- id_rs1  in  XLEN  register-file rs1 value
- id_rs2  in  XLEN  register-file rs2 value
- fwd_sel_a  in  2  operand A source: 00 = rs1, 01 = mem_wb_data, 10 = ex_mem_data, 11 = rs1
- fwd_sel_b  in  2  operand B source, same encoding as fwd_sel_a
- ex_mem_data  in  XLEN  forwarded EX/MEM result
- mem_wb_data  in  XLEN  forwarded MEM/WB result
- base_result  in  XLEN  base ALU result for non-M instructions
- downstream_stall  in  1  MEM stage stalled; hold EX/MEM
- flush  in  1  kill the instruction currently in EX
- fwd_a  out  XLEN  forwarded operand A (combinational, to the base ALU)
- fwd_b  out  XLEN  forwarded operand B (combinational, to the base ALU)
- ex_stall  out  1  EX busy; upstream must hold ID/EX stable
- out_valid  out  1  EX/MEM valid
- out_pc  out  XLEN  EX/MEM PC
- out_instr  out  32  EX/MEM instruction
- out_result  out  XLEN  EX/MEM result
- out_rs2  out  XLEN  EX/MEM forwarded store data (fwd_b)

Behaviour:
- M-op decode: id_valid && opcode == 0110011 && funct7 == 0000001.
- funct3 mapping: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states:
  - IDLE:
    - M-op present and !flush: latch fwd_a, fwd_b and funct3 into internal operand registers.
    - Special divide case (see below): go to DONE next cycle.
    - Otherwise, multiply: go to MUL with counter = MUL_STAGES-1.
    - Otherwise, divide: go to DIV with counter = XLEN/DIV_BITS_PER_CYCLE-1.
  - MUL / DIV:
    - Decrement the counter each cycle.
    - At counter == 0, go to DONE with the result latched.
  - DONE:
    - If !downstream_stall: EX/MEM loads the M result with out_valid = 1; go to IDLE.
    - If downstream_stall: hold in DONE.
- ex_stall = (IDLE && M-op) || MUL || DIV. It is low in DONE, so ID/EX may advance on the same edge EX/MEM loads.
- Latency, mul: ex_stall is high for MUL_STAGES+1 cycles, and out_valid rises MUL_STAGES+2 edges after the op first appears.
- Latency, div: as for mul, with XLEN/DIV_BITS_PER_CYCLE in place of MUL_STAGES.
- Non-M instruction in IDLE: ex_stall = 0. EX/MEM loads base_result, fwd_b, pc and instr when !downstream_stall. out_valid = id_valid && !flush.
- EX/MEM while MUL or DIV with !downstream_stall: load a bubble (out_valid = 0; other fields don't-care, driven 0).
- EX/MEM with downstream_stall: hold all fields in every state.
- Forwarding reads the latched operands during MUL/DIV/DONE, so changes on ex_mem_data or mem_wb_data after capture have no effect.
- Arithmetic:
  - MUL returns the low XLEN bits of the product.
  - MULH, MULHSU and MULHU return the high XLEN bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
  - Divide is restoring and operates on magnitudes. The sign of the quotient and the remainder is fixed at the end: quotient negative iff operand signs differ; remainder takes the dividend's sign.
- Special divide cases:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (-2^(XLEN-1) / -1): DIV returns the dividend; REM returns 0.
- flush:
  - Forces the FSM to IDLE from any state and discards the in-flight op.
  - EX/MEM loads a bubble if !downstream_stall, otherwise holds.
- rst has priority over flush. On rst:
  - FSM → IDLE, counter 0, operand registers 0.
  - out_valid, out_pc, out_instr, out_result, out_rs2 all 0.
  - ex_stall is therefore 0 the cycle after reset, unless an M-op is present in ID/EX.
- rst mid-operation aborts the op with no EX/MEM write.

Test Plan:
1. MUL_STAGES=2. MUL 7 × 0xFFFFFFFD → ex_stall high 3 cycles; out_result = 0xFFFFFFEB, out_valid 1 cycle later. Then MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
2. DIVU 100/7 → 14 after 33 stalled cycles. Divide 0xFFFFFFF9 by 2: REM → 0xFFFFFFFF; DIV → 0xFFFFFFFD. Repeat with DIV_BITS_PER_CYCLE=2 → stalled cycles drop to 17.
3. DIV x/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0. Each completes with 1 stall cycle.
4. fwd_sel_a = 10 captures ex_mem_data = 6, which then changes to 99 during MUL; fwd_b = 5 → result 30. Back-to-back ADD after MUL → out_valid on consecutive edges, no lost or duplicate instruction.
5. downstream_stall held 4 cycles while in DONE → EX/MEM and FSM hold. Release → single valid output with the correct result.
6. flush at DIV cycle 10 → FSM IDLE next cycle, bubble into EX/MEM, ex_stall 0. rst asserted mid-MUL → all outputs 0, with no result written.

Source files
------------

// File: rtl/execute_md_stage.sv
// EX stage with RV32M multiply/divide, operand forwarding and EX/MEM register.
// Ports: ID/EX inputs, forwarding data, base ALU result, stall/flush; fwd_a/b, ex_stall, EX/MEM outputs.
module execute_md_stage #(
  parameter int XLEN = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_rs1,
  input  logic [XLEN-1:0] id_rs2,
  input  logic [1:0]      fwd_sel_a,
  input  logic [1:0]      fwd_sel_b,
  input  logic [XLEN-1:0] ex_mem_data,
  input  logic [XLEN-1:0] mem_wb_data,
  input  logic [XLEN-1:0] base_result,
  input  logic            downstream_stall,
  input  logic            flush,
  output logic [XLEN-1:0] fwd_a,
  output logic [XLEN-1:0] fwd_b,
  output logic            ex_stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_rs2
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_STAGES - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(XLEN / DIV_BITS_PER_CYCLE - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a, r_b, r_res, r_pc;
  logic [1:0]      r_f3;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_rem, r_quo, r_dvs;

  logic            w_idle, w_mop, w_isdiv, w_dsgn, w_isrem;
  logic            w_dz, w_ovf;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_sel_a, w_sel_b, w_spec, w_amag, w_bmag;

  assign w_idle  = (r_state == S_IDLE);
  assign w_mop   = id_valid && (id_instr[6:0] == 7'b0110011)
                   && (id_instr[31:25] == 7'b0000001);
  assign w_f3    = id_instr[14:12];
  assign w_isdiv = w_f3[2];
  assign w_dsgn  = !w_f3[0];
  assign w_isrem = w_f3[1];

  always_comb begin
    case (fwd_sel_a)
      2'b01:   w_sel_a = mem_wb_data;
      2'b10:   w_sel_a = ex_mem_data;
      default: w_sel_a = id_rs1;
    endcase
    case (fwd_sel_b)
      2'b01:   w_sel_b = mem_wb_data;
      2'b10:   w_sel_b = ex_mem_data;
      default: w_sel_b = id_rs2;
    endcase
  end

  // Once an M-op is captured, the ALU sees the frozen operands.
  assign fwd_a = w_idle ? w_sel_a : r_a;
  assign fwd_b = w_idle ? w_sel_b : r_b;

  assign ex_stall = (w_idle && w_mop) || (r_state == S_MUL)
                    || (r_state == S_DIV);

  assign w_dz   = (fwd_b == '0);
  assign w_ovf  = w_dsgn && (fwd_a == MIN_NEG) && (&fwd_b);
  assign w_spec = w_dz ? (w_isrem ? fwd_a : '1)
                       : (w_isrem ? '0 : fwd_a);
  assign w_amag = (w_dsgn && fwd_a[XLEN-1]) ? -fwd_a : fwd_a;
  assign w_bmag = (w_dsgn && fwd_b[XLEN-1]) ? -fwd_b : fwd_b;

  // Multiply: sign-extend to 2*XLEN; the low 2*XLEN product bits are exact.
  logic            w_asx, w_bsx;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
  logic [XLEN-1:0] w_mul_res;

  assign w_asx = (r_f3 == 2'b01) || (r_f3 == 2'b10);
  assign w_bsx = (r_f3 == 2'b01);
  assign w_ma  = {{XLEN{w_asx & r_a[XLEN-1]}}, r_a};
  assign w_mb  = {{XLEN{w_bsx & r_b[XLEN-1]}}, r_b};
  assign w_prod = w_ma * w_mb;
  assign w_mul_res = (r_f3 == 2'b00) ? w_prod[XLEN-1:0]
                                     : w_prod[2*XLEN-1:XLEN];

  // Restoring divide on magnitudes, DIV_BITS_PER_CYCLE steps per clock.
  logic [XLEN:0]   w_t;
  logic [XLEN-1:0] w_rem_n, w_quo_n, w_qfix, w_rfix;
  logic            w_qneg, w_rneg;

  always_comb begin
    w_t     = '0;
    w_rem_n = r_rem;
    w_quo_n = r_quo;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      w_t     = {w_rem_n, w_quo_n[XLEN-1]};
      w_quo_n = {w_quo_n[XLEN-2:0], 1'b0};
      if (w_t >= {1'b0, r_dvs}) begin
        w_t        = w_t - {1'b0, r_dvs};
        w_quo_n[0] = 1'b1;
      end
      w_rem_n = w_t[XLEN-1:0];
    end
  end

  assign w_qneg = !r_f3[0] && (r_a[XLEN-1] ^ r_b[XLEN-1]);
  assign w_rneg = !r_f3[0] && r_a[XLEN-1];
  assign w_qfix = w_qneg ? -w_quo_n : w_quo_n;
  assign w_rfix = w_rneg ? -w_rem_n : w_rem_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_f3    <= '0;
      r_pc    <= '0;
      r_instr <= '0;
      r_res   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_mop) begin
          r_a     <= fwd_a;
          r_b     <= fwd_b;
          r_f3    <= w_f3[1:0];
          r_pc    <= id_pc;
          r_instr <= id_instr;
          if (w_isdiv && (w_dz || w_ovf)) begin
            r_res   <= w_spec;
            r_state <= S_DONE;
          end else if (!w_isdiv) begin
            r_cnt   <= MUL_CNT;
            r_state <= S_MUL;
          end else begin
            r_cnt   <= DIV_CNT;
            r_rem   <= '0;
            r_quo   <= w_amag;
            r_dvs   <= w_bmag;
            r_state <= S_DIV;
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            r_res   <= w_mul_res;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_n;
          r_quo <= w_quo_n;
          if (r_cnt == '0) begin
            r_res   <= r_f3[1] ? w_rfix : w_qfix;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: if (!downstream_stall) r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
      out_result <= '0;
      out_rs2    <= '0;
    end else if (!downstream_stall) begin
      if (flush || ex_stall) begin
        out_valid  <= 1'b0;
        out_pc     <= '0;
        out_instr  <= '0;
        out_result <= '0;
        out_rs2    <= '0;
      end else if (r_state == S_DONE) begin
        out_valid  <= 1'b1;
        out_pc     <= r_pc;
        out_instr  <= r_instr;
        out_result <= r_res;
        out_rs2    <= r_b;
      end else begin
        out_valid  <= id_valid;
        out_pc     <= id_pc;
        out_instr  <= id_instr;
        out_result <= base_result;
        out_rs2    <= fwd_b;
      end
    end
  end

endmodule

// File: tb/tb_execute_md_stage.sv
// Directed testbench for execute_md_stage.
// Two instances: one bit/cycle and two bits/cycle divide.
module tb_execute_md_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, sel2;
  logic [31:0] id_pc, id_instr, id_rs1, id_rs2;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [31:0] ex_mem_data, mem_wb_data, base_result;
  logic        downstream_stall, flush;
  logic        v1, v2;

  assign v1 = id_valid & ~sel2;
  assign v2 = id_valid & sel2;

  logic [31:0] fa1, fb1, opc1, oin1, ores1, ors1;
  logic        st1, ov1;
  logic [31:0] fa2, fb2, opc2, oin2, ores2, ors2;
  logic        st2, ov2;

  execute_md_stage #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .id_valid(v1), .id_pc(id_pc),
    .id_instr(id_instr), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .ex_mem_data(ex_mem_data), .mem_wb_data(mem_wb_data),
    .base_result(base_result), .downstream_stall(downstream_stall),
    .flush(flush), .fwd_a(fa1), .fwd_b(fb1), .ex_stall(st1),
    .out_valid(ov1), .out_pc(opc1), .out_instr(oin1),
    .out_result(ores1), .out_rs2(ors1)
  );

  execute_md_stage #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .id_valid(v2), .id_pc(id_pc),
    .id_instr(id_instr), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .ex_mem_data(ex_mem_data), .mem_wb_data(mem_wb_data),
    .base_result(base_result), .downstream_stall(downstream_stall),
    .flush(flush), .fwd_a(fa2), .fwd_b(fb2), .ex_stall(st2),
    .out_valid(ov2), .out_pc(opc2), .out_instr(oin2),
    .out_result(ores2), .out_rs2(ors2)
  );

  localparam logic [31:0] ADD = 32'h002081B3;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic wait_stall(input bit s2, output int n);
    n = 0;
    #1;
    while ((s2 ? st2 : st1) && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_op(input string tag, input bit s2,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int exp_st);
    int n;
    sel2 = s2;
    id_instr = mk(f3);
    id_rs1 = a;
    id_rs2 = b;
    id_pc = 32'h100;
    fwd_sel_a = 2'b00;
    fwd_sel_b = 2'b00;
    id_valid = 1'b1;
    wait_stall(s2, n);
    id_valid = 1'b0;
    @(negedge clk);
    check({tag, ".valid"}, 32'(s2 ? ov2 : ov1), 32'd1);
    check({tag, ".res"}, s2 ? ores2 : ores1, exp);
    check({tag, ".stall"}, 32'(n), 32'(exp_st));
    @(negedge clk);
    check({tag, ".once"}, 32'(s2 ? ov2 : ov1), 32'd0);
  endtask

  initial begin
    int n, cnt;
    rst = 1'b1; id_valid = 1'b0; sel2 = 1'b0;
    id_pc = '0; id_instr = '0; id_rs1 = '0; id_rs2 = '0;
    fwd_sel_a = '0; fwd_sel_b = '0;
    ex_mem_data = '0; mem_wb_data = '0; base_result = '0;
    downstream_stall = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.valid", 32'(ov1), 32'd0);
    check("rst.stall", 32'(st1), 32'd0);
    check("rst.res", ores1, 32'd0);
    check("rst.pc", opc1, 32'd0);
    @(negedge clk);

    run_op("mul", 0, 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 3);
    run_op("mulh", 0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 3);
    run_op("mulhu", 0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3);
    run_op("mulhsu", 0, 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 3);

    run_op("divu", 0, 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("rem", 0, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("div", 0, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("remu", 0, 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu2", 1, 3'b101, 32'd100, 32'd7, 32'd14, 17);
    run_op("div2", 1, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 17);
    run_op("rem2", 1, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 17);
    sel2 = 1'b0;

    run_op("div0", 0, 3'b100, 32'd123, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu0", 0, 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("divovf", 0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", 0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    // forwarded operand is frozen, then an ADD follows back-to-back
    id_instr = mk(3'b000); id_pc = 32'h200;
    fwd_sel_a = 2'b10; ex_mem_data = 32'd6; id_rs1 = 32'd1;
    fwd_sel_b = 2'b00; id_rs2 = 32'd5; id_valid = 1'b1;
    @(negedge clk);
    ex_mem_data = 32'd99;
    #1;
    check("fwd.latched", fa1, 32'd6);
    wait_stall(0, n);
    id_instr = ADD; id_pc = 32'h204; base_result = 32'h1234;
    fwd_sel_a = 2'b00; id_rs2 = 32'h55;
    @(negedge clk);
    check("b2b.mvalid", 32'(ov1), 32'd1);
    check("b2b.mres", ores1, 32'd30);
    check("b2b.minstr", oin1, mk(3'b000));
    check("b2b.mpc", opc1, 32'h200);
    @(negedge clk);
    check("b2b.avalid", 32'(ov1), 32'd1);
    check("b2b.ares", ores1, 32'h1234);
    check("b2b.apc", opc1, 32'h204);
    check("b2b.ars2", ors1, 32'h55);
    id_valid = 1'b0;
    @(negedge clk);
    check("b2b.end", 32'(ov1), 32'd0);

    // downstream stall while result is ready
    id_instr = mk(3'b000); id_rs1 = 32'd3; id_rs2 = 32'd4;
    id_pc = 32'h240; id_valid = 1'b1;
    wait_stall(0, n);
    downstream_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dst.hold", 32'(ov1), 32'd0);
      check("dst.stall", 32'(st1), 32'd0);
    end
    downstream_stall = 1'b0;
    id_valid = 1'b0;
    @(negedge clk);
    check("dst.valid", 32'(ov1), 32'd1);
    check("dst.res", ores1, 32'd12);
    @(negedge clk);
    check("dst.once", 32'(ov1), 32'd0);

    // flush during divide
    id_instr = mk(3'b101); id_rs1 = 32'd100; id_rs2 = 32'd7;
    id_valid = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1; id_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    fwd_sel_a = 2'b01; mem_wb_data = 32'hABC;
    #1;
    check("fl.stall", 32'(st1), 32'd0);
    check("fl.valid", 32'(ov1), 32'd0);
    check("fl.fwdlive", fa1, 32'hABC);
    fwd_sel_a = 2'b00;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov1) cnt++;
    end
    check("fl.noresult", 32'(cnt), 32'd0);

    // reset mid-multiply with EX/MEM holding a valid ADD
    id_instr = ADD; id_pc = 32'h300; base_result = 32'h77;
    id_rs2 = 32'h9; id_valid = 1'b1;
    @(negedge clk);
    check("rs.add", 32'(ov1), 32'd1);
    downstream_stall = 1'b1;
    id_instr = mk(3'b000); id_rs1 = 32'd2; id_rs2 = 32'd3;
    @(negedge clk);
    check("rs.held", ores1, 32'h77);
    rst = 1'b1; id_valid = 1'b0;
    @(negedge clk);
    check("rs.valid", 32'(ov1), 32'd0);
    check("rs.pc", opc1, 32'd0);
    check("rs.instr", oin1, 32'd0);
    check("rs.res", ores1, 32'd0);
    check("rs.rs2", ors1, 32'd0);
    check("rs.stall", 32'(st1), 32'd0);
    rst = 1'b0; downstream_stall = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov1) cnt++;
    end
    check("rs.noresult", 32'(cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
